aes_key_sched_ctrl: RTL

AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

---
 rtl/aes_key_sched_ctrl_pkg.sv | 35 +++
 rtl/aes_key_sched_ctrl_if.sv | 39 +++
 rtl/aes_key_sched_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/aes_key_sched_ctrl_pkg.sv
// Shared AES encodings and round-count helpers for the key schedule controller
// and the key expander that sits next to it.
package aes_key_sched_ctrl_pkg;

    typedef enum logic {
        AES_ENC = 1'b0,
        AES_DEC = 1'b1
    } aes_mode_e;

    typedef enum logic [2:0] {
        AES_128 = 3'b001,
        AES_192 = 3'b010,
        AES_256 = 3'b100
    } aes_key_len_e;

    localparam logic [3:0] NR_AES_128 = 4'd10;
    localparam logic [3:0] NR_AES_192 = 4'd12;
    localparam logic [3:0] NR_AES_256 = 4'd14;

    function automatic logic [3:0] aes_nr(input logic [2:0] key_len);
        logic [3:0] nr;
        case (key_len)
            AES_192: nr = NR_AES_192;
            AES_256: nr = NR_AES_256;
            default: nr = NR_AES_128;
        endcase
        return nr;
    endfunction

    // AES-192 is only legal when the expander was built with support for it.
    function automatic logic key_len_legal(input logic [2:0] key_len, input bit aes192_en);
        return $onehot(key_len) && !((key_len == AES_192) && !aes192_en);
    endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_if.sv
// Bundles the request, key-expander and round-key channels of the key schedule
// controller so environments can pass them around as one object.
interface aes_key_sched_ctrl_if;
    import aes_key_sched_ctrl_pkg::*;

    logic         start;
    logic         abort;
    logic         mode;
    logic [2:0]   key_len;
    logic [255:0] key_init;
    logic         busy;
    logic         done;
    logic         err;
    logic         ke_clear;
    logic         ke_step;
    logic [3:0]   ke_round;
    logic         ke_mode;
    logic [2:0]   ke_key_len;
    logic [255:0] ke_key;
    logic [255:0] ke_key_nxt;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk;

    // master: requester / expander / consumer side driving the controller
    modport master (
        output start, abort, mode, key_len, key_init, ke_key_nxt, rk_ready,
        input  busy, done, err, ke_clear, ke_step, ke_round, ke_mode,
               ke_key_len, ke_key, rk_valid, rk
    );

    // slave: the controller itself
    modport slave (
        input  start, abort, mode, key_len, key_init, ke_key_nxt, rk_ready,
        output busy, done, err, ke_clear, ke_step, ke_round, ke_mode,
               ke_key_len, ke_key, rk_valid, rk
    );

endinterface

// File: rtl/aes_key_sched_ctrl.sv
// Sequences the AES key expander: clears it, then hands out Nr+1 round keys
// over a valid/ready channel, stepping the expander on each accepted key.
//
// state  | meaning
// IDLE   | waiting for start_i; illegal key length pulses err_o
// CLEAR  | one cycle of ke_clear_o, round counter at 0
// EMIT   | round key valid, held until rk_ready_i
// FINISH | one cycle done_o pulse
module aes_key_sched_ctrl
    import aes_key_sched_ctrl_pkg::*;
#(
    parameter bit AES192Enable = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic         abort_i,
    input  logic         mode_i,
    input  logic [2:0]   key_len_i,
    input  logic [255:0] key_init_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o,
    output logic         ke_clear_o,
    output logic         ke_step_o,
    output logic [3:0]   ke_round_o,
    output logic         ke_mode_o,
    output logic [2:0]   ke_key_len_o,
    output logic [255:0] ke_key_o,
    input  logic [255:0] ke_key_i,
    output logic         rk_valid_o,
    input  logic         rk_ready_i,
    output logic [127:0] rk_o
);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        EMIT,
        FINISH
    } state_e;

    state_e       state_q;
    logic [3:0]   round_q;
    logic [255:0] key_full_q;
    aes_mode_e    mode_q;
    aes_key_len_e key_len_q;
    logic         err_q;
    logic [3:0]   nr;
    logic         last_round;

    assign nr         = aes_nr(key_len_q);
    assign last_round = (round_q >= nr);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            round_q    <= 4'd0;
            key_full_q <= '0;
            mode_q     <= AES_ENC;
            key_len_q  <= AES_128;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            // abort wins over any handshake: no step, no key update
            if (abort_i && (state_q != IDLE)) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_i) begin
                            if (key_len_legal(key_len_i, AES192Enable)) begin
                                mode_q     <= aes_mode_e'(mode_i);
                                key_len_q  <= aes_key_len_e'(key_len_i);
                                key_full_q <= key_init_i;
                                round_q    <= 4'd0;
                                state_q    <= CLEAR;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    CLEAR: begin
                        round_q <= 4'd0;
                        state_q <= EMIT;
                    end
                    EMIT: begin
                        if (rk_ready_i) begin
                            if (!last_round) begin
                                key_full_q <= ke_key_i;
                                round_q    <= round_q + 4'd1;
                            end else begin
                                state_q <= FINISH;
                            end
                        end
                    end
                    FINISH: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == FINISH) && !abort_i;
    assign err_o        = err_q;
    assign ke_clear_o   = (state_q == CLEAR) && !abort_i;
    assign rk_valid_o   = (state_q == EMIT) && !abort_i;
    assign ke_step_o    = rk_valid_o && rk_ready_i && !last_round;
    assign ke_round_o   = round_q;
    assign ke_mode_o    = mode_q;
    assign ke_key_len_o = key_len_q;
    assign ke_key_o     = key_full_q;
    assign rk_o         = key_full_q[255:128];

endmodule
